banked_regfile: RTL and testbench

- Parametrised multi-core register file: one private bank of DEPTH x DATA_W registers per core, selected by core_id.
- Provides NUM_RD combinational read ports and one synchronous write port, with optional write-to-read bypass and a hardwired-zero register 0.
- A sequential per-bank clear engine wipes one core's bank without resetting the whole array, for core restart.
- Sits between decode and execute of every core slice in the multi-core processor.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_bank.sv | 39 +++
 rtl/banked_regfile.sv | 131 +++++++++++++
 tb/tb_banked_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the banked register file: clear-FSM state encoding,
// default widths and a helper that pulls one port's field out of a packed bus.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_BUS_W  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Field `port` of `width` bits from a packed multi-port bus, zero-extended.
  function automatic logic [63:0] port_field(input logic [MAX_BUS_W-1:0] bus,
                                             input int port, input int width);
    logic [63:0] f;
    f = 64'(bus >> (port * width));
    if (width < 64) f = f & ((64'd1 << width) - 64'd1);
    return f;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// One DEPTH x DATA_W register bank: async clear on reset, one write port,
// one clear-write port (wins over the write port), NUM_RD combinational reads.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_we,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      if (we)     mem_q[wr_addr]  <= wr_data;
      if (clr_we) mem_q[clr_addr] <= '0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_data[i*DATA_W +: DATA_W] =
      mem_q[ADDR_W'(port_field(MAX_BUS_W'(rd_addr), i, ADDR_W))];
  end

endmodule

// File: rtl/banked_regfile.sv
// Per-core banked register file with read bypass, hardwired r0 and a
// sequential clear engine that wipes one bank over DEPTH cycles.
module banked_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_CORES = 4,
  parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int NUM_RD    = 2,
  parameter bit BYPASS    = 1'b1,
  parameter bit R0_ZERO   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CORE_W-1:0]        core_id,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  input  logic [CORE_W-1:0]        clr_core,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  clr_state_e               state_q;
  logic [CORE_W-1:0]        tgt_q;
  logic [ADDR_W-1:0]        idx_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     core_vld;
  logic                     clr_vld;
  logic                     tgt_hit;
  logic                     wr_ok;
  logic [NUM_RD*DATA_W-1:0] bank_rd [NUM_CORES];
  logic [NUM_RD*DATA_W-1:0] rd_d;
  logic [ADDR_W-1:0]        ra_d;
  logic [DATA_W-1:0]        sel_d;

  assign core_vld = int'(core_id) < NUM_CORES;
  assign clr_vld  = int'(clr_core) < NUM_CORES;
  assign tgt_hit  = busy_q && (core_id == tgt_q);
  assign wr_ok    = we && core_vld && !(R0_ZERO && (wr_addr == '0)) && !tgt_hit;

  // busy/clr_done are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clr_req && clr_vld) begin
            tgt_q   <= clr_core;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_done = done_q;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_bank
    regfile_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (wr_ok && (core_id == CORE_W'(c))),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .clr_we   (busy_q && (tgt_q == CORE_W'(c))),
      .clr_addr (idx_q),
      .rd_addr  (rd_addr),
      .rd_data  (bank_rd[c])
    );
  end

  always_comb begin
    rd_d  = '0;
    ra_d  = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_d  = ADDR_W'(port_field(MAX_BUS_W'(rd_addr), i, ADDR_W));
      sel_d = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_id == CORE_W'(c)) sel_d = bank_rd[c][i*DATA_W +: DATA_W];
      end
      if (R0_ZERO && (ra_d == '0))                  rd_d[i*DATA_W +: DATA_W] = '0;
      else if (tgt_hit || !core_vld)                rd_d[i*DATA_W +: DATA_W] = '0;
      else if (BYPASS && wr_ok && (wr_addr == ra_d)) rd_d[i*DATA_W +: DATA_W] = wr_data;
      else                                          rd_d[i*DATA_W +: DATA_W] = sel_d;
    end
  end

  assign rd_data = rd_d;

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile: reset, bypass, r0, bank isolation,
// clear engine timing/conflicts and reset in the middle of a clear.
module tb_banked_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  core_id;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic [1:0]  clr_core;
  logic        busy;
  logic        clr_done;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  banked_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .core_id  (core_id),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_core (clr_core),
    .busy     (busy),
    .clr_done (clr_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int c, input int a1, input int a0);
    core_id = 2'(c);
    rd_addr = {5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic wr(input int c, input int a, input logic [31:0] d);
    core_id = 2'(c);
    we      = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    we      = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int n;

    rst = 1'b0; core_id = '0; rd_addr = '0; we = 1'b0; wr_addr = '0;
    wr_data = '0; clr_req = 1'b0; clr_core = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(clr_done), 32'd0);
    rst = 1'b1;

    set_rd(2, 18, 20);
    check("reset_rd0", rd_data[31:0], 32'd0);
    check("reset_rd1", rd_data[63:32], 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Same-cycle bypass, then array value on the following cycle
    core_id = 2'd2; we = 1'b1; wr_addr = 5'd1; wr_data = 32'h11111111;
    rd_addr = {5'd1, 5'd0};
    #1;
    check("bypass_p1", rd_data[63:32], 32'h11111111);
    check("bypass_p0_r0", rd_data[31:0], 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("stored_p1", rd_data[63:32], 32'h11111111);

    // r0 write is dropped and never bypassed
    core_id = 2'd1; we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("r0_no_bypass", rd_data[31:0], 32'd0);
    tick();
    we = 1'b0;
    wr(1, 7, 32'hA5A5A5A5);
    set_rd(1, 7, 0);
    check("c1_r7", rd_data[63:32], 32'hA5A5A5A5);
    check("c1_r0", rd_data[31:0], 32'd0);
    set_rd(2, 7, 0);
    check("c2_r7_isolated", rd_data[63:32], 32'd0);

    for (int r = 1; r < 32; r++) begin
      wr(3, r, 32'(r));
      wr(0, r, 32'(r + 256));
    end
    set_rd(3, 31, 5);
    check("c3_r31_filled", rd_data[63:32], 32'd31);
    check("c3_r5_filled", rd_data[31:0], 32'd5);

    // Clear core 3 with a dropped target write, an ignored second request
    // and a landing write to core 0 along the way
    clr_req = 1'b1; clr_core = 2'd3;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc == 3) begin
        core_id = 2'd3; we = 1'b1; wr_addr = 5'd31; wr_data = 32'h1234;
        clr_req = 1'b1; clr_core = 2'd1; rd_addr = {5'd31, 5'd31};
        #1;
        check("target_read_zero", rd_data[63:32], 32'd0);
      end else if (cyc == 5) begin
        core_id = 2'd0; we = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE;
        rd_addr = {5'd5, 5'd1};
        #1;
        check("other_bank_bypass", rd_data[63:32], 32'hCAFE);
        check("other_bank_r1", rd_data[31:0], 32'h101);
      end
      tick();
      we = 1'b0; clr_req = 1'b0;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd32);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'd32);

    set_rd(3, 31, 1);
    check("c3_r31_cleared", rd_data[63:32], 32'd0);
    check("c3_r1_cleared", rd_data[31:0], 32'd0);
    set_rd(3, 16, 30);
    check("c3_r16_cleared", rd_data[63:32], 32'd0);
    check("c3_r30_cleared", rd_data[31:0], 32'd0);
    set_rd(0, 5, 31);
    check("c0_r5_written", rd_data[63:32], 32'hCAFE);
    check("c0_r31_kept", rd_data[31:0], 32'h11F);
    set_rd(1, 7, 0);
    check("c1_not_cleared", rd_data[63:32], 32'hA5A5A5A5);
    set_rd(2, 1, 0);
    check("c2_r1_kept", rd_data[63:32], 32'h11111111);

    // Reset in the middle of a clear
    clr_req = 1'b1; clr_core = 2'd2;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    check("midclear_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(clr_done), 32'd0);
    tick();
    check("abort_done_later", 32'(clr_done), 32'd0);
    rst = 1'b1;
    set_rd(1, 7, 0);
    check("rst_c1_r7", rd_data[63:32], 32'd0);
    set_rd(0, 5, 31);
    check("rst_c0_r5", rd_data[63:32], 32'd0);
    check("rst_c0_r31", rd_data[31:0], 32'd0);

    // New clear accepted; same-edge write to the target is later wiped
    core_id = 2'd1; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    clr_req = 1'b1; clr_core = 2'd1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    check("new_clear_busy", 32'(busy), 32'd1);
    n = 0;
    while (!clr_done && n < 100) begin
      tick();
      n++;
    end
    check("new_clear_done", 32'(clr_done), 32'd1);
    check("new_clear_len", 32'(n), 32'd32);
    tick();
    check("done_one_cycle", 32'(clr_done), 32'd0);
    set_rd(1, 9, 0);
    check("same_edge_write_cleared", rd_data[63:32], 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
